// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU load/store path, the copy engine controls and the
// single-port data memory. The master side is the environment, the slave side is the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              dma_start;
    logic [ADDR_W-1:0] dma_src;
    logic [ADDR_W-1:0] dma_dst;
    logic [ADDR_W-1:0] dma_len;
    logic              dma_busy;
    logic              dma_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_start, dma_src, dma_dst, dma_len,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, dma_busy, dma_done,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_start, dma_src, dma_dst, dma_len,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, dma_busy, dma_done,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (priority) and a byte-wise
// read-then-write block-copy engine, with a starvation limiter forcing DMA slots.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    dmem_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int              CNT_W    = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic            LIMIT_EN = (STARVE_LIMIT != 0);

    state_t            state_r;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W-1:0] len_r;
    logic [DATA_W-1:0] buf_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              dma_active_s;
    logic              forced_s;
    logic              cpu_grant_s;
    logic              dma_grant_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Grant decision: CPU wins unless the copy engine has been starved to the limit.
    always_comb begin
        dma_active_s = (state_r == RD) || (state_r == WR);
        forced_s     = LIMIT_EN && dma_active_s && (stall_cnt_r == LIMIT);
        cpu_grant_s  = bus.cpu_req && !forced_s;
        dma_grant_s  = dma_active_s && !cpu_grant_s;
    end

    // Memory port mux between the CPU request and the copy engine's current step.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = bus.cpu_addr;
        mem_wdata_s = bus.cpu_wdata;
        if (dma_grant_s) begin
            case (state_r)
                RD: begin
                    mem_addr_s = src_r + idx_r;
                end
                WR: begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = dst_r + idx_r;
                    mem_wdata_s = buf_r;
                end
                default: begin
                    mem_we_s = 1'b0;
                end
            endcase
        end else begin
            mem_we_s = cpu_grant_s && bus.cpu_we;
        end
    end

    // Copy-engine FSM, latched job parameters and starvation counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            src_r       <= '0;
            dst_r       <= '0;
            len_r       <= '0;
            buf_r       <= '0;
            stall_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.dma_start) begin
                        src_r   <= bus.dma_src;
                        dst_r   <= bus.dma_dst;
                        len_r   <= bus.dma_len;
                        idx_r   <= '0;
                        state_r <= (bus.dma_len != '0) ? RD : DONE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    if (dma_grant_s) begin
                        buf_r   <= bus.mem_rdata;
                        state_r <= WR;
                    end else begin
                        state_r <= RD;
                    end
                end
                WR: begin
                    if (dma_grant_s) begin
                        idx_r   <= idx_r + ADDR_W'(1'b1);
                        state_r <= (idx_r == len_r - ADDR_W'(1'b1)) ? DONE : RD;
                    end else begin
                        state_r <= WR;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            // Counts consecutive cycles the engine lost to the CPU; saturates at the limit.
            if (!dma_active_s || dma_grant_s) begin
                stall_cnt_r <= '0;
            end else if (stall_cnt_r != LIMIT) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // A write already on the port when Reset arrives must not reach the memory.
    assign bus.mem_we    = mem_we_s & ~Reset;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = bus.cpu_req && forced_s;
    assign bus.dma_busy  = dma_active_s;
    assign bus.dma_done  = (state_r == DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: behavioural 256x8 memory, write scoreboards for CPU and DMA
// traffic, a table of CPU-path vectors and hand-written copy sequences.
module tb_dmem_arbiter;

    logic Clk;
    logic Reset;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) ifc ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifc)
    );

    logic [7:0] mem [0:255];
    assign ifc.mem_rdata = mem[ifc.mem_addr];
    always @(posedge Clk) begin
        if (ifc.mem_we) mem[ifc.mem_addr] <= ifc.mem_wdata;
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] cpu_q [$];
    logic [15:0] dma_q [$];

    logic [63:0] we_mask, stall_mask, busy_mask;
    int          done_at, done_cnt;
    logic [7:0]  addr_at [0:63];

    typedef struct {
        logic       req;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       exp_we;
        logic [7:0] exp_addr;
        logic [7:0] exp_wdata;
        logic       rd_chk;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called once per cycle at the falling edge: every write on the port must match a scoreboard entry.
    task automatic monitor();
        logic [15:0] e;
        if (ifc.mem_we === 1'b1) begin
            if (ifc.cpu_req && ifc.cpu_we && !ifc.cpu_stall) begin
                if (cpu_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cpu_wr_unexpected: got addr %0h data %0h expected no write", ifc.mem_addr, ifc.mem_wdata);
                end else begin
                    e = cpu_q.pop_front();
                    chk("cpu_wr", {ifc.mem_addr, ifc.mem_wdata}, e);
                end
            end else begin
                if (dma_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dma_wr_unexpected: got addr %0h data %0h expected no write", ifc.mem_addr, ifc.mem_wdata);
                end else begin
                    e = dma_q.pop_front();
                    chk("dma_wr", {ifc.mem_addr, ifc.mem_wdata}, e);
                end
            end
        end
    endtask

    task automatic idle_inputs();
        ifc.cpu_req   = 1'b0;
        ifc.cpu_we    = 1'b0;
        ifc.cpu_addr  = 8'h00;
        ifc.cpu_wdata = 8'h00;
        ifc.dma_start = 1'b0;
        ifc.dma_src   = 8'h00;
        ifc.dma_dst   = 8'h00;
        ifc.dma_len   = 8'h00;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge Clk); #1;
        idle_inputs();
        ifc.cpu_req = 1'b1; ifc.cpu_we = 1'b1; ifc.cpu_addr = a; ifc.cpu_wdata = d;
        cpu_q.push_back({a, d});
        @(negedge Clk);
        monitor();
    endtask

    task automatic cpu_read(input string name, input logic [7:0] a, input logic [7:0] exp);
        @(posedge Clk); #1;
        idle_inputs();
        ifc.cpu_req = 1'b1; ifc.cpu_addr = a;
        @(negedge Clk);
        monitor();
        chk(name, {ifc.cpu_stall, ifc.cpu_rdata}, {1'b0, exp});
    endtask

    // Start edge is the end of this cycle; expected destination writes are queued up front.
    task automatic start(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len, input int npush);
        logic [7:0] sa, da;
        @(posedge Clk); #1;
        idle_inputs();
        ifc.dma_start = 1'b1; ifc.dma_src = src; ifc.dma_dst = dst; ifc.dma_len = len;
        for (int i = 0; i < npush; i++) begin
            sa = src + 8'(i);
            da = dst + 8'(i);
            dma_q.push_back({da, mem[sa]});
        end
        @(negedge Clk);
        monitor();
    endtask

    // Runs cycles 1..ncyc after the start edge with an optional CPU window, stray start pulse and reset.
    task automatic run(input int ncyc, input int lo, input int hi, input logic we,
                       input logic [7:0] a, input logic [7:0] d, input int pulse_at, input int rst_at);
        we_mask = '0; stall_mask = '0; busy_mask = '0; done_at = 0; done_cnt = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge Clk); #1;
            idle_inputs();
            Reset = (c == rst_at);
            if (c >= lo && c <= hi) begin
                ifc.cpu_req = 1'b1; ifc.cpu_we = we; ifc.cpu_addr = a; ifc.cpu_wdata = d;
                if (we) cpu_q.push_back({a, d});
            end
            if (c == pulse_at) begin
                ifc.dma_start = 1'b1; ifc.dma_src = 8'h00; ifc.dma_dst = 8'h30; ifc.dma_len = 8'h05;
            end
            @(negedge Clk);
            monitor();
            we_mask[c]    = ifc.mem_we;
            stall_mask[c] = ifc.cpu_stall;
            busy_mask[c]  = ifc.dma_busy;
            addr_at[c]    = ifc.mem_addr;
            if (ifc.dma_done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
        end
        Reset = 1'b0;
        chk("dma_q_drained", 64'(dma_q.size()), 64'd0);
        chk("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] m;
        Reset = 1'b1;
        idle_inputs();

        // Reset with random inputs
        repeat (2) begin
            @(posedge Clk); #1;
            ifc.cpu_req   = 1'($urandom_range(0, 1));
            ifc.cpu_we    = 1'($urandom_range(0, 1));
            ifc.cpu_addr  = 8'($urandom_range(0, 255));
            ifc.cpu_wdata = 8'($urandom_range(0, 255));
            ifc.dma_start = 1'($urandom_range(0, 1));
            ifc.dma_src   = 8'($urandom_range(0, 255));
            ifc.dma_dst   = 8'($urandom_range(0, 255));
            ifc.dma_len   = 8'($urandom_range(0, 255));
            @(negedge Clk);
            monitor();
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        idle_inputs();
        @(negedge Clk);
        monitor();
        chk("reset_outputs", {ifc.dma_busy, ifc.dma_done, ifc.cpu_stall, ifc.mem_we}, 4'b0000);

        // Preload through the CPU path
        for (int i = 0; i < 32; i++) cpu_write(8'(i), 8'(i) ^ 8'h5A);
        for (int i = 252; i < 256; i++) cpu_write(8'(i), 8'(i) ^ 8'h5A);
        cpu_write(8'h10, 8'hA1);
        cpu_write(8'h11, 8'hB2);
        cpu_write(8'h12, 8'hC3);

        // CPU pass-through vectors while the engine is idle
        vecs[0] = '{1'b1, 1'b1, 8'h80, 8'h3C, 1'b1, 8'h80, 8'h3C, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 8'h80, 8'h00, 1'b1, 8'h3C};
        vecs[2] = '{1'b1, 1'b1, 8'h81, 8'hE7, 1'b1, 8'h81, 8'hE7, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 8'h81, 8'h00, 1'b0, 8'h81, 8'h00, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 8'h81, 8'h00, 1'b1, 8'hE7};
        vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA1};
        for (int v = 0; v < 6; v++) begin
            @(posedge Clk); #1;
            idle_inputs();
            ifc.cpu_req = vecs[v].req; ifc.cpu_we = vecs[v].we;
            ifc.cpu_addr = vecs[v].addr; ifc.cpu_wdata = vecs[v].wdata;
            if (vecs[v].req && vecs[v].we) cpu_q.push_back({vecs[v].addr, vecs[v].wdata});
            @(negedge Clk);
            monitor();
            chk($sformatf("vec%0d_port", v), {ifc.mem_we, ifc.mem_addr, ifc.cpu_stall},
                {vecs[v].exp_we, vecs[v].exp_addr, 1'b0});
            if (vecs[v].exp_we) chk($sformatf("vec%0d_wdata", v), ifc.mem_wdata, vecs[v].exp_wdata);
            if (vecs[v].rd_chk) chk($sformatf("vec%0d_rdata", v), ifc.cpu_rdata, vecs[v].exp_rdata);
        end

        // Plain copy
        start(8'h10, 8'h40, 8'd3, 3);
        run(12, 0, 0, 1'b0, 8'h00, 8'h00, 0, 0);
        chk("plain_we_cycles", we_mask, 64'h54);
        chk("plain_done_at", 64'(done_at), 64'd7);
        chk("plain_done_cnt", 64'(done_cnt), 64'd1);
        chk("plain_busy", busy_mask, 64'h7E);
        cpu_read("plain_dst0", 8'h40, 8'hA1);
        cpu_read("plain_dst1", 8'h41, 8'hB2);
        cpu_read("plain_dst2", 8'h42, 8'hC3);

        // CPU preemption on cycles 3-4
        start(8'h10, 8'h40, 8'd3, 3);
        run(12, 3, 4, 1'b1, 8'h80, 8'h55, 0, 0);
        chk("preempt_we_cycles", we_mask, 64'h15C);
        chk("preempt_done_at", 64'(done_at), 64'd9);
        chk("preempt_stall", stall_mask, 64'h0);
        cpu_read("preempt_cpu_wr", 8'h80, 8'h55);
        cpu_read("preempt_dst1", 8'h41, 8'hB2);
        cpu_read("preempt_dst2", 8'h42, 8'hC3);

        // Starvation limiter: CPU reads held for 20 cycles during a 20-byte copy
        start(8'h00, 8'hA0, 8'd20, 20);
        run(62, 1, 20, 1'b0, 8'h05, 8'h00, 0, 0);
        chk("starve_stall_cycles", stall_mask, (64'd1 << 9) | (64'd1 << 18));
        m = 64'd1 << 18;
        for (int k = 0; k < 19; k++) m = m | (64'd1 << (22 + 2 * k));
        chk("starve_we_cycles", we_mask, m);
        chk("starve_done_at", 64'(done_at), 64'd59);
        cpu_read("starve_dst_first", 8'hA0, 8'h5A);
        cpu_read("starve_dst_last", 8'hB3, 8'h49);

        // Address wrap with a stray start pulse while busy
        start(8'hFE, 8'h20, 8'd4, 4);
        run(12, 0, 0, 1'b0, 8'h00, 8'h00, 3, 0);
        chk("wrap_rd_addrs", {addr_at[1], addr_at[3], addr_at[5], addr_at[7]}, 32'hFEFF0001);
        chk("wrap_done_at", 64'(done_at), 64'd9);
        chk("wrap_done_cnt", 64'(done_cnt), 64'd1);
        cpu_read("wrap_dst2", 8'h22, 8'h5A);
        cpu_read("wrap_dst1", 8'h21, 8'hA5);

        // Zero-length copy
        start(8'h00, 8'h50, 8'd0, 0);
        run(4, 0, 0, 1'b0, 8'h00, 8'h00, 0, 0);
        chk("noop_done_at", 64'(done_at), 64'd1);
        chk("noop_we", we_mask, 64'h0);
        chk("noop_busy", busy_mask, 64'h0);

        // Reset during the 5th write of a 10-byte copy
        start(8'h00, 8'h60, 8'd10, 4);
        run(20, 0, 0, 1'b0, 8'h00, 8'h00, 0, 10);
        chk("rstmid_we_cycles", we_mask, 64'h154);
        chk("rstmid_done_cnt", 64'(done_cnt), 64'd0);
        chk("rstmid_idle", {ifc.dma_busy, ifc.dma_done}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
